// File: rtl/product_accumulator.sv
// Product accumulator: sums a job of len unsigned 8-bit products into an
// ACC_WIDTH-bit accumulator with a sticky carry-out flag, then holds the
// result under a valid/ready handshake.
module product_accumulator #(
    parameter int unsigned ACC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 start,
    input  logic [3:0]           len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_product,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic                 out_ovf,
    output logic                 busy
);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic [3:0]           rem_q, rem_d;
    logic [ACC_WIDTH:0]   sum_ext;

    // One extra bit captures the carry out of the accumulator MSB.
    assign sum_ext = {1'b0, acc_q} + {{(ACC_WIDTH - 7){1'b0}}, in_product};

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            rem_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state and datapath update; clear overrides everything else.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        rem_d   = rem_q;
        if (clear) begin
            state_d = StIdle;
            acc_d   = '0;
            ovf_d   = 1'b0;
            rem_d   = 4'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        acc_d = '0;
                        ovf_d = 1'b0;
                        if (len == 4'd0) begin
                            state_d = StDone;
                        end else begin
                            rem_d   = len;
                            state_d = StAccum;
                        end
                    end
                end
                StAccum: begin
                    if (in_valid) begin
                        acc_d = sum_ext[ACC_WIDTH-1:0];
                        ovf_d = ovf_q | sum_ext[ACC_WIDTH];
                        rem_d = rem_q - 4'd1;
                        if (rem_q == 4'd1) begin
                            state_d = StDone;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Handshake outputs decode registered state only.
    always_comb begin
        in_ready  = (state_q == StAccum);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        out_sum   = acc_q;
        out_ovf   = ovf_q;
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench: two accumulators (16-bit and 9-bit) share one stimulus
// stream; expected results come from plain integer totals of each job.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        start;
    logic [3:0]  len;
    logic        in_valid;
    logic [7:0]  in_product;
    logic        out_ready;

    logic        in_ready16, out_valid16, out_ovf16, busy16;
    logic [15:0] out_sum16;
    logic        in_ready9, out_valid9, out_ovf9, busy9;
    logic [8:0]  out_sum9;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] s16;
        logic        o16;
        logic [8:0]  s9;
        logic        o9;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] prods[$];

    product_accumulator #(.ACC_WIDTH(16)) dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .start      (start),
        .len        (len),
        .in_valid   (in_valid),
        .in_ready   (in_ready16),
        .in_product (in_product),
        .out_valid  (out_valid16),
        .out_ready  (out_ready),
        .out_sum    (out_sum16),
        .out_ovf    (out_ovf16),
        .busy       (busy16)
    );

    product_accumulator #(.ACC_WIDTH(9)) dut9 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .start      (start),
        .len        (len),
        .in_valid   (in_valid),
        .in_ready   (in_ready9),
        .in_product (in_product),
        .out_valid  (out_valid9),
        .out_ready  (out_ready),
        .out_sum    (out_sum9),
        .out_ovf    (out_ovf9),
        .busy       (busy9)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: carry out ever occurs iff the job total reaches 2^W.
    function automatic exp_t model(input int total);
        exp_t e;
        e.s16 = 16'(total % 65536);
        e.o16 = (total >= 65536);
        e.s9  = 9'(total % 512);
        e.o9  = (total >= 512);
        return e;
    endfunction

    // Monitor: compare every presented result, pop on handshake.
    always @(negedge clk) begin
        if (rst_n && (out_valid16 || out_valid9)) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got out_valid=1 expected no result (t=%0t)",
                         $time);
            end else begin
                check("out_valid9_match", out_valid9, out_valid16);
                check("out_sum16", out_sum16, sb_q[0].s16);
                check("out_ovf16", out_ovf16, sb_q[0].o16);
                check("out_sum9", out_sum9, sb_q[0].s9);
                check("out_ovf9", out_ovf9, sb_q[0].o9);
                if (out_ready) void'(sb_q.pop_front());
            end
        end
    end

    // Runs one job over prods[] with random input gaps and an output stall.
    task automatic do_job(input int max_gap, input int stall, input bit ign);
        int   n;
        int   total;
        exp_t e;
        n     = prods.size();
        total = 0;
        foreach (prods[i]) total += int'(prods[i]);
        e = model(total);
        sb_q.push_back(e);

        @(posedge clk); #1;
        start     = 1'b1;
        len       = 4'(n);
        out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        len   = 4'($urandom_range(0, 15));

        if (n == 0) begin
            @(negedge clk);
            check("zero_len_out_valid", out_valid16, 1'b1);
            check("zero_len_in_ready", in_ready16, 1'b0);
        end else begin
            for (int i = 0; i < n; i++) begin
                int gaps;
                gaps = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
                repeat (gaps) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                    check("gap_in_ready", in_ready16, 1'b1);
                    @(posedge clk); #1;
                end
                in_valid   = 1'b1;
                in_product = prods[i];
                if (ign && i == 0) begin
                    start = 1'b1;
                    len   = ~4'(n);
                end
                @(negedge clk);
                check("in_ready", in_ready16, 1'b1);
                check("out_valid_early", out_valid16, 1'b0);
                @(posedge clk); #1;
                start    = 1'b0;
                in_valid = 1'b0;
            end
            @(negedge clk);
            check("latency_out_valid", out_valid16, 1'b1);
            check("done_in_ready", in_ready16, 1'b0);
        end

        repeat (stall) @(negedge clk);
        @(posedge clk); #1;
        out_ready = 1'b1;
        if (ign) begin
            start = 1'b1;
            len   = 4'd5;
        end
        @(negedge clk);
        check("handshake_out_valid", out_valid16, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        start     = 1'b0;
        @(negedge clk);
        check("idle_busy", busy16, 1'b0);
        check("idle_out_valid", out_valid16, 1'b0);
        check("hold_sum16", out_sum16, e.s16);
        check("hold_sum9", out_sum9, e.s9);
        check("hold_ovf9", out_ovf9, e.o9);
    endtask

    task automatic abort_tests();
        // Clear after two of five products, with a third offered alongside clear.
        @(posedge clk); #1;
        start = 1'b1;
        len   = 4'd5;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid   = 1'b1;
            in_product = 8'($urandom_range(1, 255));
            @(posedge clk); #1;
        end
        clear      = 1'b1;
        in_valid   = 1'b1;
        in_product = 8'h77;
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("clear_busy", busy16, 1'b0);
        check("clear_in_ready", in_ready16, 1'b0);
        check("clear_sum16", out_sum16, 16'd0);
        check("clear_ovf16", out_ovf16, 1'b0);
        repeat (3) @(negedge clk);
        check("clear_stays_idle", busy16, 1'b0);

        // Asynchronous reset in the middle of a job.
        @(posedge clk); #1;
        start = 1'b1;
        len   = 4'd3;
        @(posedge clk); #1;
        start      = 1'b0;
        in_valid   = 1'b1;
        in_product = 8'hC8;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy16, 1'b0);
        check("rst_in_ready", in_ready16, 1'b0);
        check("rst_sum16", out_sum16, 16'd0);
        check("rst_sum9", out_sum9, 9'd0);
        check("rst_out_valid", out_valid16, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", busy16, 1'b0);

        prods.delete();
        prods.push_back(8'h31);
        do_job(0, 0, 1'b0);
        check("after_abort_sum", out_sum16, 16'd49);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish before 2ms");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        clear      = 1'b0;
        start      = 1'b0;
        len        = 4'd0;
        in_valid   = 1'b0;
        in_product = 8'd0;
        out_ready  = 1'b0;
        #2;
        check("reset_busy", busy16, 1'b0);
        check("reset_in_ready", in_ready16, 1'b0);
        check("reset_out_valid", out_valid16, 1'b0);
        check("reset_sum16", out_sum16, 16'd0);
        check("reset_ovf9", out_ovf9, 1'b0);
        #10;
        rst_n = 1'b1;

        // Four back-to-back 0xFF: 1020 at 16 bits.
        prods = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        do_job(0, 0, 1'b0);
        check("basic_sum16", out_sum16, 16'd1020);

        // Three 255s: 765 wraps to 253 at 9 bits with overflow.
        prods = '{8'd255, 8'd255, 8'd255};
        do_job(0, 0, 1'b0);
        check("ovf_sum9", out_sum9, 9'd253);
        check("ovf_flag9", out_ovf9, 1'b1);

        // Gapped input and a long output stall.
        prods = '{8'd17, 8'd200, 8'd99};
        do_job(3, 5, 1'b0);

        // Zero length job.
        prods.delete();
        do_job(0, 0, 1'b0);
        check("zero_len_sum", out_sum16, 16'd0);

        // Start pulses in ACCUM and DONE must be ignored.
        prods = '{8'd10, 8'd20, 8'd30, 8'd40};
        do_job(1, 1, 1'b1);
        check("ignored_start_sum", out_sum16, 16'd100);

        abort_tests();

        for (int j = 0; j < 24; j++) begin
            int n;
            n = $urandom_range(0, 15);
            prods.delete();
            for (int i = 0; i < n; i++) prods.push_back(8'($urandom_range(0, 255)));
            do_job($urandom_range(0, 3), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter: ACC_WIDTH, 16, accumulator/result width; legal range 8..32.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: clear  input  1  synchronous abort; returns block to IDLE.
REQ-005 SHALL have port: start  input  1  begin an accumulation job; sampled only in IDLE.
REQ-006 SHALL have port: len  input  4  number of products in the job; sampled with start.
REQ-007 SHALL have port: in_valid  input  1  in_product valid.
REQ-008 SHALL have port: in_ready  output  1  block accepts a product this cycle.
REQ-009 SHALL have port: in_product  input  8  unsigned 8-bit product from the 4x4 multiplier.
REQ-010 SHALL have port: out_valid  output  1  result available.
REQ-011 SHALL have port: out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port: out_sum  output  ACC_WIDTH  accumulated sum, modulo 2^ACC_WIDTH.
REQ-013 SHALL have port: out_ovf  output  1  sticky flag: a carry out of bit ACC_WIDTH-1 occurred during the job.
REQ-014 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement the states IDLE, ACCUM and DONE.
REQ-016 In IDLE: in_ready=0, out_valid=0, busy=0.
REQ-017 In IDLE, start=1 with len!=0 SHALL set acc=0, ovf=0 and remaining=len, then enter ACCUM next cycle.
REQ-018 In IDLE, start=1 with len=0 SHALL set acc=0 and ovf=0 and enter DONE directly, giving out_sum=0.
REQ-019 In ACCUM: in_ready=1.
REQ-020 A transfer occurs on in_valid&&in_ready.
REQ-021 On each transfer: acc <= (acc + zero-extended in_product) mod 2^ACC_WIDTH; ovf <= ovf | carry; remaining decrements.
REQ-022 A cycle in ACCUM without in_valid SHALL leave acc, ovf and remaining unchanged; gaps are unlimited.
REQ-023 A transfer with remaining==1 SHALL enter DONE; out_valid rises on the cycle after the final transfer (latency 1).
REQ-024 In DONE: out_valid=1, in_ready=0; out_sum and out_ovf reflect the final acc/ovf and stay stable until the handshake.
REQ-025 In DONE, out_valid&&out_ready SHALL return the block to IDLE next cycle.
REQ-026 out_sum and out_ovf SHALL hold their last values in IDLE until the next start.
REQ-027 start SHALL be ignored in ACCUM and DONE, including when it coincides with the output handshake; len is not re-sampled.
REQ-028 clear=1 SHALL force IDLE next cycle from any state, taking priority over start, transfers and handshakes.
REQ-029 clear SHALL reset acc and ovf to 0; a product offered in the same cycle is not consumed.
REQ-030 in_ready and out_valid SHALL be decoded from registered state only, with no combinational path from in_valid or out_ready.

Reset
REQ-031 While rst_n=0: state=IDLE, acc=0, ovf=0, remaining=0, out_sum=0, out_ovf=0, in_ready=0, out_valid=0, busy=0, independent of clk.
REQ-032 Reset asserted mid-job SHALL discard the job; after release the block waits in IDLE for a new start.

Verification
REQ-033 Basic job: ACC_WIDTH=16, start len=4, four back-to-back products 0xFF -> out_valid 1 cycle after 4th, out_sum=1020, out_ovf=0.
REQ-034 Overflow: ACC_WIDTH=9, len=3, products 255,255,255 -> out_sum=253, out_ovf=1.
REQ-035 Flow control: len=3, in_valid toggled with gaps, out_ready held low 5 cycles -> sum equals product total, out_sum stable throughout the stall, IDLE 1 cycle after out_ready.
REQ-036 Zero length: start len=0 -> out_valid next cycle, out_sum=0, out_ovf=0, in_ready never high.
REQ-037 Abort: clear after 2 of 5 products, then rst_n pulsed during a later job -> IDLE, acc=0, no out_valid; next job of len=1 product 0x31 gives out_sum=49.
REQ-038 Ignored start: start pulsed in ACCUM with different len -> original len honoured, result unchanged.
